// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW hazard scoreboard with freeze and multi-cycle branch flush
module hazard_scoreboard #(
    parameter int NUM_STAGES   = 3,
    parameter int REG_W        = 4,
    parameter int FORWARD_EN   = 0,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_W-1:0]      id_src1,
    input  logic                  id_src1_en,
    input  logic [REG_W-1:0]      id_src2,
    input  logic                  id_src2_en,
    input  logic                  id_wb_en,
    input  logic [REG_W-1:0]      id_dest,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
    output logic                  hazard,
    output logic                  freeze,
    output logic                  flush,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]      stall_count
);

    // The branch itself supplies the first flush cycle; the counter covers the rest.
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [NUM_STAGES-1:0] wb_q, wb_d;
    logic [NUM_STAGES-1:0] mr_q, mr_d;
    logic [REG_W-1:0]      dest_q [NUM_STAGES];
    logic [REG_W-1:0]      dest_d [NUM_STAGES];
    logic [2:0]            flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic [NUM_STAGES-1:0] match;
    logic                  raw;
    logic                  flush_active;
    logic                  issue;

    // Compare every in-flight writer against the sources the ID instruction reads.
    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            match[k] = valid_q[k] && wb_q[k] &&
                       ((id_src1_en && (dest_q[k] == id_src1)) ||
                        (id_src2_en && (dest_q[k] == id_src2)));
        end
    end

    // With forwarding only a load sitting in EXE cannot be bypassed in time.
    assign raw = id_valid && ((FORWARD_EN != 0) ? (match[0] && mr_q[0]) : (|match));

    // Outputs are gated by reset so they drop the instant reset asserts.
    assign flush_active = branch_taken || (flush_cnt_q != 3'd0);
    assign flush        = rst && flush_active;
    assign hazard       = rst && raw && !flush_active;
    assign freeze       = hazard;
    assign stage_valid  = valid_q;
    assign stall_count  = stall_cnt_q;

    // Only an instruction that is neither stalled nor discarded enters the pipe.
    assign issue = id_valid && !hazard && !flush;

    // Next-state: shift the scoreboard, run the flush counter, bump the stall counter.
    always_comb begin
        valid_d   = '0;
        wb_d      = '0;
        mr_d      = '0;
        dest_d    = dest_q;
        valid_d[0] = issue;
        wb_d[0]    = id_wb_en;
        mr_d[0]    = id_mem_read;
        dest_d[0]  = id_dest;
        for (int k = 1; k < NUM_STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            wb_d[k]    = wb_q[k-1];
            mr_d[k]    = mr_q[k-1];
            dest_d[k]  = dest_q[k-1];
        end

        flush_cnt_d = flush_cnt_q;
        if (branch_taken) begin
            flush_cnt_d = FLUSH_RELOAD;
        end else if (flush_cnt_q != 3'd0) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
        end

        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset empties the pipe and cancels any pending flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            wb_q        <= '0;
            mr_q        <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                dest_q[k] <= '0;
            end
            flush_cnt_q <= 3'd0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            wb_q        <= wb_d;
            mr_q        <= mr_d;
            dest_q      <= dest_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
